sprite_motion_ctrl: RTL and testbench

- Moves the on-screen square once per frame from tilt data, and presents the square's bounding box to the VGA pixel renderer.
- Sits between the accelerometer movement bus (10-bit packed tilt) and the pixel-colour logic, on the pixel clock.
- Updates only during vertical blanking, so the box is stable for the whole visible frame.
- Clamps the square to the visible area and reports edge hits.

---
 rtl/sprite_motion_ctrl.sv | 118 +++++++++++
 tb/tb_sprite_motion_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: moves the square once per frame from tilt data during vertical blanking,
// clamping it to the visible area and reporting which edges were hit.
module sprite_motion_ctrl #(
    parameter int HLINES    = 640,
    parameter int VLINES    = 480,
    parameter int SIZE      = 40,
    parameter int FRAME_DIV = 1,
    parameter int DEADZONE  = 1
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic [10:0] hcounter,
    input  logic [10:0] vcounter,
    input  logic [9:0]  movement_data,
    input  logic        movement_valid,
    input  logic        recenter,
    output logic [10:0] h_min,
    output logic [10:0] h_max,
    output logic [10:0] v_min,
    output logic [10:0] v_max,
    output logic [3:0]  hit_edge,
    output logic        update_done
);
    localparam logic [10:0]        H_CTR    = 11'((HLINES - SIZE) / 2);
    localparam logic [10:0]        V_CTR    = 11'((VLINES - SIZE) / 2);
    localparam logic [10:0]        SZ       = 11'(SIZE);
    localparam logic signed [11:0] H_LIM    = 12'(HLINES - 1 - SIZE);
    localparam logic signed [11:0] V_LIM    = 12'(VLINES - 1 - SIZE);
    localparam logic signed [11:0] DZ       = 12'(DEADZONE);
    localparam logic [7:0]         DIV_LAST = 8'(FRAME_DIV - 1);

    typedef enum logic [2:0] {WAIT_FRAME, SAMPLE, CALC_H, CALC_V, COMMIT} state_t;

    state_t             state, state_next;
    logic [9:0]         hold, snap;
    logic [7:0]         frame_cnt;
    logic               recenter_pend;
    logic               frame_tick;
    logic signed [11:0] sx, sy, tx, ty, h_diff, v_diff;
    logic [10:0]        h_next, v_next;
    logic [1:0]         h_flags, v_flags;

    assign frame_tick = (vcounter == 11'(VLINES)) && (hcounter == 11'd0);

    // Tilt arithmetic is 12-bit signed so -16 and clamps below zero never wrap.
    always_comb begin
        snap   = movement_valid ? movement_data : hold;
        sx     = {{7{snap[9]}}, snap[9:5]};
        sy     = {{7{snap[4]}}, snap[4:0]};
        h_diff = $signed({1'b0, h_min}) - ty;
        v_diff = $signed({1'b0, v_min}) - tx;
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n)
            state <= WAIT_FRAME;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_FRAME: state_next = (frame_tick && frame_cnt == DIV_LAST) ? SAMPLE : WAIT_FRAME;
            SAMPLE:     state_next = CALC_H;
            CALC_H:     state_next = CALC_V;
            CALC_V:     state_next = COMMIT;
            default:    state_next = WAIT_FRAME;
        endcase
    end

    always_comb update_done = (state == COMMIT);

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            hold          <= '0;
            frame_cnt     <= '0;
            recenter_pend <= 1'b0;
            tx            <= '0;
            ty            <= '0;
            h_next        <= '0;
            v_next        <= '0;
            h_flags       <= '0;
            v_flags       <= '0;
            h_min         <= H_CTR;
            h_max         <= H_CTR + SZ;
            v_min         <= V_CTR;
            v_max         <= V_CTR + SZ;
            hit_edge      <= '0;
        end else begin
            if (movement_valid)
                hold <= movement_data;
            // A pulse landing on the commit cycle survives to the next update.
            recenter_pend <= recenter || (recenter_pend && state != COMMIT);
            if (state == WAIT_FRAME && frame_tick)
                frame_cnt <= (frame_cnt == DIV_LAST) ? 8'd0 : frame_cnt + 8'd1;
            if (state == SAMPLE) begin
                tx <= (sx <= DZ && sx >= -DZ) ? 12'sd0 : sx;
                ty <= (sy <= DZ && sy >= -DZ) ? 12'sd0 : sy;
            end
            if (state == CALC_H) begin
                h_next  <= 11'(h_diff < 0 ? 12'sd0 : (h_diff > H_LIM ? H_LIM : h_diff));
                h_flags <= {h_diff < 0, h_diff > H_LIM};
            end
            if (state == CALC_V) begin
                v_next  <= 11'(v_diff < 0 ? 12'sd0 : (v_diff > V_LIM ? V_LIM : v_diff));
                v_flags <= {v_diff < 0, v_diff > V_LIM};
            end
            if (state == COMMIT) begin
                h_min    <= recenter_pend ? H_CTR : h_next;
                h_max    <= (recenter_pend ? H_CTR : h_next) + SZ;
                v_min    <= recenter_pend ? V_CTR : v_next;
                v_max    <= (recenter_pend ? V_CTR : v_next) + SZ;
                hit_edge <= recenter_pend ? 4'd0 : {h_flags, v_flags};
            end
        end
    end
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: drives compressed frames into two configurations of the controller
// and compares every cycle against a frame-level model of the motion rules.
module tb_sprite_motion_ctrl;
    logic             pixel_clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             movement_valid = 1'b0;
    logic             recenter = 1'b0;
    logic [10:0]      hcounter = '0;
    logic [10:0]      vcounter = '0;
    logic [9:0]       movement_data = '0;
    logic [1:0][10:0] h_min, h_max, v_min, v_max;
    logic [1:0][3:0]  hit_edge;
    logic [1:0]       update_done;

    localparam int FD [2] = '{1, 3};
    localparam int DZ [2] = '{1, 2};

    int         checks = 0;
    int         errors = 0;
    int         m_h [2], m_v [2], m_hit [2], m_cnt [2], m_since [2], m_tx [2], m_ty [2];
    bit         m_pend [2];
    logic [9:0] m_hold;

    sprite_motion_ctrl u0 (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .hcounter(hcounter), .vcounter(vcounter),
        .movement_data(movement_data), .movement_valid(movement_valid), .recenter(recenter),
        .h_min(h_min[0]), .h_max(h_max[0]), .v_min(v_min[0]), .v_max(v_max[0]),
        .hit_edge(hit_edge[0]), .update_done(update_done[0])
    );

    sprite_motion_ctrl #(.FRAME_DIV(3), .DEADZONE(2)) u1 (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .hcounter(hcounter), .vcounter(vcounter),
        .movement_data(movement_data), .movement_valid(movement_valid), .recenter(recenter),
        .h_min(h_min[1]), .h_max(h_max[1]), .v_min(v_min[1]), .v_max(v_max[1]),
        .hit_edge(hit_edge[1]), .update_done(update_done[1])
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int tilt(input logic [4:0] t, input int dz);
        int s;
        s = t[4] ? int'(t) - 32 : int'(t);
        return (s <= dz && s >= -dz) ? 0 : s;
    endfunction

    function automatic int clamp(input int x, input int hi);
        return x < 0 ? 0 : (x > hi ? hi : x);
    endfunction

    task automatic commit(input int i);
        int h, v;
        if (m_pend[i]) begin
            m_h[i]   = 300;
            m_v[i]   = 220;
            m_hit[i] = 0;
        end else begin
            h        = m_h[i] - m_ty[i];
            v        = m_v[i] - m_tx[i];
            m_hit[i] = (h < 0 ? 8 : 0) + (h > 599 ? 4 : 0) + (v < 0 ? 2 : 0) + (v > 439 ? 1 : 0);
            m_h[i]   = clamp(h, 599);
            m_v[i]   = clamp(v, 439);
        end
    endtask

    // Advances the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit         tick;
        logic [9:0] s;
        tick = (vcounter == 11'd480) && (hcounter == 11'd0);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_h[i] = 300; m_v[i] = 220; m_hit[i] = 0;
                m_cnt[i] = 0; m_since[i] = 0; m_pend[i] = 0;
                continue;
            end
            if (m_since[i] == 1) begin
                s = movement_valid ? movement_data : m_hold;
                m_tx[i] = tilt(s[9:5], DZ[i]);
                m_ty[i] = tilt(s[4:0], DZ[i]);
            end
            if (m_since[i] == 4) begin
                commit(i);
                m_pend[i]  = 0;
                m_since[i] = 0;
            end else if (m_since[i] > 0) begin
                m_since[i]++;
            end else if (tick) begin
                m_cnt[i]++;
                if (m_cnt[i] == FD[i]) begin
                    m_cnt[i]   = 0;
                    m_since[i] = 1;
                end
            end
            if (recenter)
                m_pend[i] = 1;
        end
        if (!rst_n)
            m_hold = '0;
        else if (movement_valid)
            m_hold = movement_data;
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d.h_min", i), 32'(h_min[i]), m_h[i]);
            check($sformatf("u%0d.h_max", i), 32'(h_max[i]), m_h[i] + 40);
            check($sformatf("u%0d.v_min", i), 32'(v_min[i]), m_v[i]);
            check($sformatf("u%0d.v_max", i), 32'(v_max[i]), m_v[i] + 40);
            check($sformatf("u%0d.hit_edge", i), 32'(hit_edge[i]), m_hit[i]);
            check($sformatf("u%0d.update_done", i), 32'(update_done[i]), m_since[i] == 4 ? 1 : 0);
        end
    endtask

    task automatic cycle();
        @(negedge pixel_clk);
        compare_all();
        model_step();
        @(posedge pixel_clk);
        #1;
    endtask

    // One compressed frame; offsets rc_at/rst_at are relative to the frame_tick cycle.
    task automatic frame(input bit rnd, input int rc_at, input int rst_at);
        for (int k = -10; k < 11; k++) begin
            if (k < 0) begin
                vcounter = 11'($urandom_range(0, 479));
                hcounter = 11'($urandom_range(0, 799));
            end else if (k < 9) begin
                vcounter = 11'd480;
                hcounter = 11'(k);
            end else begin
                vcounter = 11'($urandom_range(481, 2047));
                hcounter = 11'($urandom_range(0, 2047));
            end
            if (rnd) begin
                movement_valid = ($urandom_range(0, 3) == 0);
                movement_data  = 10'($urandom);
                recenter       = ($urandom_range(0, 40) == 0);
                rst_n          = ($urandom_range(0, 300) != 0);
            end else begin
                movement_valid = (k == -5);
                recenter       = (k == rc_at);
                rst_n          = (k != rst_at);
            end
            cycle();
        end
        movement_valid = 1'b0;
        recenter       = 1'b0;
        rst_n          = 1'b1;
    endtask

    task automatic frames(input int n);
        repeat (n) frame(1'b0, -99, -99);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        model_step();
        @(posedge pixel_clk);
        #1;
        cycle();
        rst_n = 1'b1;
        check("rst h_min", 32'(h_min[0]), 300);
        check("rst h_max", 32'(h_max[0]), 340);
        check("rst v_min", 32'(v_min[0]), 220);
        check("rst v_max", 32'(v_max[0]), 260);
        check("rst hit_edge", 32'(hit_edge[0]), 0);
        check("rst update_done", 32'(update_done[0]), 0);

        movement_data = 10'h000;
        frames(3);
        check("still h_min", 32'(h_min[0]), 300);
        check("still v_min", 32'(v_min[0]), 220);

        do_reset();
        movement_data = 10'h01C;
        frames(5);
        check("ty-4 h_min", 32'(h_min[0]), 320);
        check("ty-4 h_max", 32'(h_max[0]), 360);
        check("ty-4 v_min", 32'(v_min[0]), 220);
        check("ty-4 model", m_h[0], 320);

        do_reset();
        movement_data = 10'h00F;
        frames(20);
        check("ty15 reach0", 32'(h_min[0]), 0);
        frames(5);
        check("ty15 h_min", 32'(h_min[0]), 0);
        check("ty15 h_max", 32'(h_max[0]), 40);
        check("ty15 left", 32'(hit_edge[0]), 4'b1000);

        do_reset();
        movement_data = 10'h200;
        frames(20);
        check("tx-16 v_min", 32'(v_min[0]), 439);
        check("tx-16 v_max", 32'(v_max[0]), 479);
        check("tx-16 bottom", 32'(hit_edge[0]), 4'b0001);
        check("tx-16 model", m_v[0], 439);

        do_reset();
        movement_data = 10'h001;
        frames(4);
        check("deadzone h_min", 32'(h_min[0]), 300);

        do_reset();
        movement_data = 10'h01B;
        frames(4);
        check("div3 u1 h_min4", 32'(h_min[1]), 305);
        check("div1 u0 h_min4", 32'(h_min[0]), 320);
        frames(2);
        check("div3 u1 h_min6", 32'(h_min[1]), 310);
        check("div1 u0 h_min6", 32'(h_min[0]), 330);
        check("div3 model", m_h[1], 310);

        frame(1'b0, -3, -99);
        check("recenter h_min", 32'(h_min[0]), 300);
        check("recenter v_min", 32'(v_min[0]), 220);
        check("recenter hit", 32'(hit_edge[0]), 0);
        frame(1'b0, 4, -99);
        check("rc@commit moved", 32'(h_min[0]), 305);
        frames(1);
        check("rc@commit later", 32'(h_min[0]), 300);
        frames(1);
        check("pre-reset h_min", 32'(h_min[0]), 305);
        frame(1'b0, -99, 3);
        check("reset calc_v h_min", 32'(h_min[0]), 300);
        check("reset calc_v h_max", 32'(h_max[0]), 340);

        do_reset();
        repeat (300) frame(1'b1, -99, -99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
